// File: rtl/uart_cpu_bridge.sv
// Bridge between the CPU uart port and the serial rx/tx engines.
// RX bytes are queued for req/ack reads; CPU writes are queued and sent to the transmitter one at a time.
module uart_cpu_bridge #(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     uartReadReq,
  output logic                     uartReadAck,
  output logic [7:0]               uartReadData,
  input  logic                     uartWriteReq,
  input  logic [7:0]               uartWriteData,
  output logic                     uartWriteReady,
  input  logic                     rxValid,
  input  logic [7:0]               rxData,
  output logic                     txStart,
  output logic [7:0]               txData,
  input  logic                     txBusy,
  output logic                     rxOverrun,
  output logic [RX_DEPTH_LOG2:0]   rxCount
);

  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;

  typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT_LOW} read_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT_BUSY, T_WAIT_DONE} tx_state_t;

  // ---------------- RX FIFO ----------------
  logic [7:0]             rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG2:0] rx_wr_ptr;
  logic [RX_DEPTH_LOG2:0] rx_rd_ptr;
  logic                   rx_full;
  logic                   rx_empty;
  logic                   rx_push;
  logic                   rx_pop;

  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[RX_DEPTH_LOG2-1:0] == rx_rd_ptr[RX_DEPTH_LOG2-1:0]) &&
                    (rx_wr_ptr[RX_DEPTH_LOG2] != rx_rd_ptr[RX_DEPTH_LOG2]);
  assign rx_push  = rxValid && !rx_full;
  assign rxCount  = rx_wr_ptr - rx_rd_ptr;

  // NOTE: storage arrays carry no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr[RX_DEPTH_LOG2-1:0]] <= rxData;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rxOverrun <= 1'b0;
    end else begin
      if (rx_push)           rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)            rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rxValid && rx_full) rxOverrun <= 1'b1;
    end
  end

  // ---------------- CPU read FSM ----------------
  read_state_t rd_state;
  read_state_t rd_state_next;
  logic        ack_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state     <= R_IDLE;
      uartReadAck  <= 1'b0;
      uartReadData <= '0;
    end else begin
      rd_state    <= rd_state_next;
      uartReadAck <= ack_next;
      if (rx_pop) uartReadData <= rx_mem[rx_rd_ptr[RX_DEPTH_LOG2-1:0]];
    end
  end

  // The ack flop is loaded from R_ACK, so it appears two edges after the request is seen.
  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    rd_state_next = rd_state;
    rx_pop        = 1'b0;
    ack_next      = 1'b0;
    unique case (rd_state)
      R_IDLE: begin
        if (uartReadReq && !rx_empty) begin
          rx_pop        = 1'b1;
          rd_state_next = R_ACK;
        end
      end
      R_ACK: begin
        ack_next      = 1'b1;
        rd_state_next = R_WAIT_LOW;
      end
      R_WAIT_LOW: begin
        if (!uartReadReq) rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]             tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG2:0] tx_wr_ptr;
  logic [TX_DEPTH_LOG2:0] tx_rd_ptr;
  logic [TX_DEPTH_LOG2:0] tx_wr_ptr_next;
  logic [TX_DEPTH_LOG2:0] tx_rd_ptr_next;
  logic                   tx_full_next;
  logic                   tx_empty;
  logic                   tx_push;
  logic                   tx_pop;

  assign tx_empty       = (tx_wr_ptr == tx_rd_ptr);
  assign tx_push        = uartWriteReq && uartWriteReady;
  assign tx_wr_ptr_next = tx_wr_ptr + {{TX_DEPTH_LOG2{1'b0}}, tx_push};
  assign tx_rd_ptr_next = tx_rd_ptr + {{TX_DEPTH_LOG2{1'b0}}, tx_pop};
  assign tx_full_next   = (tx_wr_ptr_next[TX_DEPTH_LOG2-1:0] == tx_rd_ptr_next[TX_DEPTH_LOG2-1:0]) &&
                          (tx_wr_ptr_next[TX_DEPTH_LOG2] != tx_rd_ptr_next[TX_DEPTH_LOG2]);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[TX_DEPTH_LOG2-1:0]] <= uartWriteData;
  end

  // Ready is registered from the post-update pointers, so it always equals "not full".
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr      <= '0;
      tx_rd_ptr      <= '0;
      uartWriteReady <= 1'b1;
    end else begin
      tx_wr_ptr      <= tx_wr_ptr_next;
      tx_rd_ptr      <= tx_rd_ptr_next;
      uartWriteReady <= !tx_full_next;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t tx_state;
  tx_state_t tx_state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= T_IDLE;
      txData   <= '0;
    end else begin
      tx_state <= tx_state_next;
      if (tx_pop) txData <= tx_mem[tx_rd_ptr[TX_DEPTH_LOG2-1:0]];
    end
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_pop        = 1'b0;
    txStart       = 1'b0;
    unique case (tx_state)
      T_IDLE: begin
        if (!tx_empty) begin
          tx_pop        = 1'b1;
          tx_state_next = T_START;
        end
      end
      T_START: begin
        txStart       = 1'b1;
        tx_state_next = T_WAIT_BUSY;
      end
      T_WAIT_BUSY: begin
        if (txBusy) tx_state_next = T_WAIT_DONE;
      end
      T_WAIT_DONE: begin
        if (!txBusy) tx_state_next = T_IDLE;
      end
      default: tx_state_next = T_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_cpu_bridge.sv
// Self-checking bench for uart_cpu_bridge: directed and randomized traffic against
// queue-based models of both FIFOs and a behavioural transmitter.
module tb_uart_cpu_bridge;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uartReadReq = 1'b0;
  logic       uartReadAck;
  logic [7:0] uartReadData;
  logic       uartWriteReq = 1'b0;
  logic [7:0] uartWriteData = 8'h00;
  logic       uartWriteReady;
  logic       rxValid = 1'b0;
  logic [7:0] rxData = 8'h00;
  logic       txStart;
  logic [7:0] txData;
  logic       txBusy;
  logic       rxOverrun;
  logic [4:0] rxCount;

  uart_cpu_bridge #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .uartReadReq    (uartReadReq),
    .uartReadAck    (uartReadAck),
    .uartReadData   (uartReadData),
    .uartWriteReq   (uartWriteReq),
    .uartWriteData  (uartWriteData),
    .uartWriteReady (uartWriteReady),
    .rxValid        (rxValid),
    .rxData         (rxData),
    .txStart        (txStart),
    .txData         (txData),
    .txBusy         (txBusy),
    .rxOverrun      (rxOverrun),
    .rxCount        (rxCount)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [7:0] rx_model[$];
  logic       exp_overrun = 1'b0;
  logic [7:0] tx_expect[$];
  int         tx_checked = 0;

  // Transmitter model observations
  logic [7:0] tx_log[$];
  int         tx_gap[$];
  int         tx_overlap = 0;
  int         tx_unstable = 0;
  bit         tx_stall = 1'b0;

  int cycle = 0;
  int ack_total = 0;
  int n_cmp = 0;
  int n_mis = 0;

  always @(posedge clk) cycle <= cycle + 1;
  always @(negedge clk) if (uartReadAck === 1'b1) ack_total <= ack_total + 1;

  // Transmitter: busy rises the cycle after txStart, lasts 8 cycles (longer while stalled).
  initial begin : tx_model
    logic [7:0] held;
    int         last_fall;
    bit         have_fall;
    txBusy    = 1'b0;
    have_fall = 1'b0;
    last_fall = 0;
    forever begin
      @(negedge clk);
      if (txStart === 1'b1 && reset === 1'b0) begin
        held = txData;
        tx_log.push_back(held);
        if (have_fall) tx_gap.push_back(cycle - last_fall);
        @(posedge clk); #1;
        txBusy = 1'b1;
        for (int k = 0; k < 8 || tx_stall; k++) begin
          @(negedge clk);
          if (txStart === 1'b1) tx_overlap++;
          if (reset === 1'b1) held = txData;
          else if (txData !== held) tx_unstable++;
          @(posedge clk); #1;
        end
        txBusy    = 1'b0;
        last_fall = cycle;
        have_fall = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rx_send(input logic [7:0] b);
    rxValid = 1'b1;
    rxData  = b;
    step();
    rxValid = 1'b0;
    if (rx_model.size() < DEPTH) rx_model.push_back(b);
    else exp_overrun = 1'b1;
  endtask

  // Polls for the ack with req already high, then releases req and lets the FSM idle.
  task automatic wait_ack(input int budget, output logic [7:0] d, output int lat);
    lat = -1;
    d   = 8'hxx;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (uartReadAck === 1'b1) begin
        lat = k - 1;
        d   = uartReadData;
        break;
      end
    end
    step();
    uartReadReq = 1'b0;
    step();
    step();
  endtask

  task automatic read_expect(input string tag);
    logic [7:0] d;
    logic [7:0] exp;
    int         lat;
    int         acks0;
    exp   = rx_model.pop_front();
    acks0 = ack_total;
    uartReadReq = 1'b1;
    wait_ack(20, d, lat);
    check({tag, "_latency"}, lat, 2);
    check({tag, "_data"}, 32'(d), 32'(exp));
    check({tag, "_ack_pulses"}, ack_total - acks0, 1);
  endtask

  task automatic tx_write(input logic [7:0] b, input bit accept);
    uartWriteReq  = 1'b1;
    uartWriteData = b;
    step();
    uartWriteReq  = 1'b0;
    if (accept) tx_expect.push_back(b);
  endtask

  task automatic tx_drain_check(input string tag);
    int budget;
    budget = 12 * (tx_expect.size() - tx_checked) + 60;
    for (int k = 0; k < budget && tx_log.size() < tx_expect.size(); k++) step();
    repeat (30) step();
    check({tag, "_start_count"}, tx_log.size(), tx_expect.size());
    for (int i = tx_checked; i < tx_expect.size(); i++)
      check({tag, "_byte"}, (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hxxxx_xxxx, 32'(tx_expect[i]));
    tx_checked = tx_expect.size();
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_ack"},      32'(uartReadAck), 0);
    check({tag, "_rdata"},    32'(uartReadData), 0);
    check({tag, "_txstart"},  32'(txStart), 0);
    check({tag, "_txdata"},   32'(txData), 0);
    check({tag, "_overrun"},  32'(rxOverrun), 0);
    check({tag, "_rxcount"},  32'(rxCount), 0);
    check({tag, "_wready"},   32'(uartWriteReady), 1);
    step();
  endtask

  initial begin : stimulus
    logic [7:0] d;
    logic [7:0] b3;
    logic [7:0] batch [17];
    int         lat;
    int         acks0;
    int         base;
    int         bad_gaps;

    // Power-on reset
    repeat (3) step();
    reset = 1'b0;
    check_reset_state("por");

    // RX basic: two bytes, two reads, then a read that stalls on an empty FIFO
    rx_send(8'h41);
    rx_send(8'h42);
    check("rx_basic_count", 32'(rxCount), rx_model.size());
    read_expect("rx_basic_first");
    read_expect("rx_basic_second");
    acks0 = ack_total;
    uartReadReq = 1'b1;
    repeat (6) step();
    check("rx_empty_no_ack", ack_total - acks0, 0);
    rx_send(8'h43);
    wait_ack(20, d, lat);
    check("rx_late_data", 32'(d), 32'(rx_model.pop_front()));
    check("rx_late_ack_pulses", ack_total - acks0, 1);
    check("rx_basic_overrun", 32'(rxOverrun), 0);

    // Held request: one ack only, data holds afterwards
    for (int i = 0; i < 3; i++) rx_send(8'($urandom));
    acks0 = ack_total;
    uartReadReq = 1'b1;
    repeat (10) step();
    uartReadReq = 1'b0;
    step();
    step();
    check("held_req_ack_pulses", ack_total - acks0, 1);
    check("held_req_data", 32'(uartReadData), 32'(rx_model.pop_front()));
    check("held_req_count", 32'(rxCount), 2);
    read_expect("held_req_drain");
    read_expect("held_req_drain");

    // Push and pop in the same cycle leave the count unchanged
    rx_send(8'($urandom));
    rx_send(8'($urandom));
    b3 = 8'($urandom);
    acks0 = ack_total;
    uartReadReq = 1'b1;
    rxValid     = 1'b1;
    rxData      = b3;
    step();
    rxValid = 1'b0;
    rx_model.push_back(b3);
    @(negedge clk);
    check("push_pop_count", 32'(rxCount), 2);
    wait_ack(20, d, lat);
    check("push_pop_data", 32'(d), 32'(rx_model.pop_front()));
    check("push_pop_ack_pulses", ack_total - acks0, 1);
    read_expect("push_pop_drain");
    read_expect("push_pop_drain");

    // Overrun: 17 bytes into a 16-deep FIFO, then drain in order
    for (int i = 0; i <= 16; i++) rx_send(8'(i));
    check("overrun_count_full", 32'(rxCount), rx_model.size());
    check("overrun_flag", 32'(rxOverrun), 32'(exp_overrun));
    for (int i = 0; i < 16; i++) read_expect("overrun_drain");
    check("overrun_count_empty", 32'(rxCount), 0);
    check("overrun_sticky", 32'(rxOverrun), 32'(exp_overrun));

    // TX drain: three back-to-back writes
    tx_write(8'h55, 1'b1);
    tx_write(8'hAA, 1'b1);
    tx_write(8'h0F, 1'b1);
    tx_drain_check("tx_drain");

    // TX full: transmitter held busy on one byte while 17 more are written
    tx_stall = 1'b1;
    tx_write(8'($urandom), 1'b1);
    for (int k = 0; k < 20 && txBusy !== 1'b1; k++) step();
    check("tx_full_busy_stuck", 32'(txBusy), 1);
    for (int i = 0; i < 17; i++) batch[i] = 8'($urandom);
    for (int i = 0; i < 17; i++) begin
      uartWriteReq  = 1'b1;
      uartWriteData = batch[i];
      @(negedge clk);
      check("tx_full_ready", 32'(uartWriteReady), 32'(i < 16));
      step();
      if (i < 16) tx_expect.push_back(batch[i]);
    end
    uartWriteReq = 1'b0;
    @(negedge clk);
    check("tx_full_ready_after", 32'(uartWriteReady), 0);
    step();
    tx_stall = 1'b0;
    tx_drain_check("tx_full");
    check("tx_full_ready_restored", 32'(uartWriteReady), 1);

    // Randomized mixed traffic
    for (int round = 0; round < 6; round++) begin
      int n_push;
      int n_read;
      int n_wr;
      n_push = $urandom_range(6, 1);
      for (int i = 0; i < n_push; i++) begin
        rx_send(8'($urandom));
        if ($urandom_range(1, 0) == 1) step();
      end
      check("rnd_rx_count", 32'(rxCount), rx_model.size());
      n_read = $urandom_range(rx_model.size(), (rx_model.size() > 3) ? rx_model.size() - 3 : 1);
      for (int i = 0; i < n_read; i++) read_expect("rnd_read");
      check("rnd_rx_count_after", 32'(rxCount), rx_model.size());
      n_wr = $urandom_range(8, 1);
      for (int i = 0; i < n_wr; i++) begin
        @(negedge clk);
        check("rnd_tx_ready", 32'(uartWriteReady), 1);
        step();
        tx_write(8'($urandom), 1'b1);
        repeat ($urandom_range(2, 0)) step();
      end
      tx_drain_check("rnd_tx");
    end
    check("rnd_overrun_sticky", 32'(rxOverrun), 32'(exp_overrun));

    // Reset mid-traffic discards everything queued
    base = tx_log.size();
    for (int i = 0; i < 3; i++) rx_send(8'($urandom));
    for (int i = 0; i < 3; i++) tx_write(8'($urandom), 1'b0);
    for (int k = 0; k < 20 && tx_log.size() == base; k++) step();
    check("reset_tx_started", tx_log.size() - base, 1);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    rx_model.delete();
    exp_overrun = 1'b0;
    check_reset_state("mid_reset");
    base = tx_log.size();
    repeat (40) step();
    check("reset_no_txstart", tx_log.size() - base, 0);
    acks0 = ack_total;
    uartReadReq = 1'b1;
    repeat (8) step();
    uartReadReq = 1'b0;
    step();
    check("reset_rx_empty_no_ack", ack_total - acks0, 0);

    // Transmitter protocol observations gathered over the whole run
    bad_gaps = 0;
    foreach (tx_gap[i]) if (tx_gap[i] < 1) bad_gaps++;
    check("tx_start_after_busy_fall", bad_gaps, 0);
    check("tx_start_while_busy", tx_overlap, 0);
    check("tx_data_stable", tx_unstable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
